traffic_sequencer: RTL and testbench
====================================

TRAFFIC_SEQUENCER -- requirements
Module: traffic_sequencer

Interface
REQ-001 Parameter T_GREEN, default 10, santa/intersection green duration in ticks.
REQ-002 Parameter T_YELLOW, default 3, yellow duration in ticks for S2, S4 and S6.
REQ-003 Parameter T_ALLRED, default 1, all-red clearance duration in ticks for S7 and S8.
REQ-004 Parameter T_PED, default 12, pedestrian-walk duration in ticks for S5.
REQ-005 Port clk  input  1  sole clock; all state updates on the rising edge.
REQ-006 Port rst  input  1  synchronous, active-high reset.
REQ-007 Port tick  input  1  one-cycle timing strobe (e.g. 1 Hz enable); timers advance only on tick.
REQ-008 Port hold  input  1  freezes the timer while high; state is unchanged.
REQ-009 Port ped_req  input  1  pedestrian button, level or pulse, sampled every clk.
REQ-010 Port color  output  3  state code driving the light decoder: S1=000 through S8=111.
REQ-011 Port ped_pending  output  1  latched pedestrian request not yet served.
REQ-012 Port remain  output  8  ticks remaining in the current state.

Function
REQ-013 color, ped_pending and remain SHALL be registered outputs.
REQ-014 States, codes and durations:
- S1 000: santa green, T_GREEN
- S2 001: santa yellow, T_YELLOW
- S7 110: all red, T_ALLRED
- S3 010: intersection green, T_GREEN
- S4 011: intersection yellow, T_YELLOW
- S5 100: intersection and pedestrian green, T_PED
- S6 101: intersection and pedestrian yellow, T_YELLOW
- S8 111: all red, T_ALLRED
REQ-015 Transitions SHALL be S1->S2->S7, then S7->S5 or S7->S3, then S3->S4->S8 or S5->S6->S8, then S8->S1.
REQ-016 On entry to any state, remain SHALL load that state's duration in the same edge that changes color.
REQ-017 On an edge with tick=1 and hold=0:
- if remain>1, remain SHALL decrement by 1;
- if remain==1, the state SHALL advance and remain SHALL reload.
REQ-018 The state SHALL remain unchanged:
- when tick=0 or hold=1, the state and remain SHALL not change;
- when hold=1 and tick=1 occur together, the tick SHALL be discarded and not deferred.
REQ-019 The S7 exit SHALL go to S5 if (ped_pending | ped_req)=1 on the exit edge, and otherwise to S3.
REQ-020 ped_pending SHALL set on any edge with ped_req=1 while the state is not S5.
REQ-021 ped_pending SHALL clear on the edge entering S5, even if ped_req=1 on that edge, because the request is served.
REQ-022 ped_req SHALL be ignored while in S5; a ped_req in S6, S8 or S1-S4 SHALL set ped_pending for the next S7 decision.
REQ-023 All durations SHALL be 1..255; the remain counter SHALL never wrap below 1 or hold 0.
REQ-024 Latency from the tick that expires a state to the new color SHALL be 1 clk.

Reset
REQ-025 When rst=1 at an edge:
- color=000 (S1), remain=T_GREEN, ped_pending=0;
- rst SHALL override tick, hold and ped_req on that edge.
REQ-026 A reset mid-state (e.g. in S5) SHALL abandon the sequence and restart at S1 with the full T_GREEN duration and no pending request.

Verification
REQ-027 The bench SHALL cover the following scenarios, using T_GREEN=4, T_YELLOW=2, T_ALLRED=1, T_PED=5, tick=1 every clk and hold=0 unless stated:
- No ped_req after reset -> color cycles 000x4, 001x2, 110x1, 010x4, 011x2, 111x1, then 000; remain counts 4,3,2,1 in S1.
- ped_req pulse during S1 -> ped_pending=1 the next clk; after S7, color=100 for 5 clks with ped_pending=0, then 101x2, 111x1, 000.
- ped_req=1 exactly on the S7-exit edge with ped_pending=0 -> the next state is S5 (100) and ped_pending stays 0.
- hold=1 for 3 clks in S3 with remain=3 -> color stays 010 and remain stays 3; after release, S3 lasts 3 more clks.
- tick every 4th clk -> each state lasts its duration x 4 clks; the transition occurs 1 clk after the expiring tick.
- rst=1 for one clk while in S5 with remain=2 -> the next clk shows color=000, remain=4, ped_pending=0.

Source files
------------

// File: rtl/traffic_sequencer.sv
// Two-road traffic light sequencer with a latched pedestrian phase, advanced by a tick strobe.
// Outputs are registered; a state change appears one clk after the tick that expires the state.
module traffic_sequencer #(
    parameter int unsigned T_GREEN  = 10,
    parameter int unsigned T_YELLOW = 3,
    parameter int unsigned T_ALLRED = 1,
    parameter int unsigned T_PED    = 12
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       hold,
    input  logic       ped_req,
    output logic [2:0] color,
    output logic       ped_pending,
    output logic [7:0] remain
);

    typedef enum logic [2:0] {
        S1 = 3'b000,
        S2 = 3'b001,
        S3 = 3'b010,
        S4 = 3'b011,
        S5 = 3'b100,
        S6 = 3'b101,
        S7 = 3'b110,
        S8 = 3'b111
    } state_t;

    // Durations are clamped to 1..255 so the counter can never load zero.
    localparam logic [7:0] D_GREEN  = (T_GREEN  == 0) ? 8'd1 : (T_GREEN  > 255) ? 8'd255 : 8'(T_GREEN);
    localparam logic [7:0] D_YELLOW = (T_YELLOW == 0) ? 8'd1 : (T_YELLOW > 255) ? 8'd255 : 8'(T_YELLOW);
    localparam logic [7:0] D_ALLRED = (T_ALLRED == 0) ? 8'd1 : (T_ALLRED > 255) ? 8'd255 : 8'(T_ALLRED);
    localparam logic [7:0] D_PED    = (T_PED    == 0) ? 8'd1 : (T_PED    > 255) ? 8'd255 : 8'(T_PED);

    function automatic logic [7:0] duration(input state_t s);
        case (s)
            S1, S3:     duration = D_GREEN;
            S2, S4, S6: duration = D_YELLOW;
            S5:         duration = D_PED;
            default:    duration = D_ALLRED;
        endcase
    endfunction

    state_t     state_q, state_d;
    logic [7:0] remain_q, remain_d;
    logic       ped_pending_q, ped_pending_d;

    always_comb begin
        state_d       = state_q;
        remain_d      = remain_q;
        ped_pending_d = ped_pending_q;

        if (ped_req && state_q != S5) begin
            ped_pending_d = 1'b1;
        end

        if (tick && !hold) begin
            if (remain_q > 8'd1) begin
                remain_d = remain_q - 8'd1;
            end else begin
                case (state_q)
                    S1:      state_d = S2;
                    S2:      state_d = S7;
                    S7:      state_d = (ped_pending_q || ped_req) ? S5 : S3;
                    S3:      state_d = S4;
                    S4:      state_d = S8;
                    S5:      state_d = S6;
                    S6:      state_d = S8;
                    default: state_d = S1;
                endcase
                remain_d = duration(state_d);
                // Entering the walk phase serves the request, even one arriving this very edge.
                if (state_d == S5) begin
                    ped_pending_d = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S1;
            remain_q      <= D_GREEN;
            ped_pending_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            remain_q      <= remain_d;
            ped_pending_q <= ped_pending_d;
        end
    end

    assign color       = state_q;
    assign remain      = remain_q;
    assign ped_pending = ped_pending_q;

endmodule

// File: tb/tb_traffic_sequencer.sv
// Directed bench for traffic_sequencer: expected outputs are queued with each stimulus step
// and popped for comparison once the DUT has taken the edge.
module tb_traffic_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick = 1'b0;
    logic       hold = 1'b0;
    logic       ped_req = 1'b0;
    logic [2:0] color;
    logic       ped_pending;
    logic [7:0] remain;

    typedef struct {
        logic [2:0] color;
        logic [7:0] remain;
        logic       pp;
        string      tag;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   passed = 0;

    traffic_sequencer #(
        .T_GREEN (4),
        .T_YELLOW(2),
        .T_ALLRED(1),
        .T_PED   (5)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .tick       (tick),
        .hold       (hold),
        .ped_req    (ped_req),
        .color      (color),
        .ped_pending(ped_pending),
        .remain     (remain)
    );

    always #5 clk = ~clk;

    // Drive one clk of stimulus, queue what the outputs must be after that edge, then check.
    task automatic step(input logic r, input logic t, input logic h, input logic p,
                        input logic [2:0] ec, input logic [7:0] er, input logic ep,
                        input string tag);
        exp_t e;
        rst     = r;
        tick    = t;
        hold    = h;
        ped_req = p;
        e.color  = ec;
        e.remain = er;
        e.pp     = ep;
        e.tag    = tag;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        checks += 3;
        assert (color === e.color) passed++;
        else $error("FAIL %s color observed=%b expected=%b", e.tag, color, e.color);
        assert (remain === e.remain) passed++;
        else $error("FAIL %s remain observed=%0d expected=%0d", e.tag, remain, e.remain);
        assert (ped_pending === e.pp) passed++;
        else $error("FAIL %s ped_pending observed=%b expected=%b", e.tag, ped_pending, e.pp);
    endtask

    // Walk a state through remain values from..to; each tick is followed by 'idle' tick-less clks.
    task automatic seq(input logic [2:0] c, input int from, input int to, input logic pp,
                       input int idle, input string tag);
        for (int r = from; r >= to; r--) begin
            step(1'b0, 1'b1, 1'b0, 1'b0, c, 8'(r), pp, tag);
            for (int k = 0; k < idle; k++) begin
                step(1'b0, 1'b0, 1'b0, 1'b0, c, 8'(r), pp, {tag, "_idle"});
            end
        end
    endtask

    initial begin
        // Reset overrides tick and ped_req on the same edge.
        step(1'b1, 1'b1, 1'b0, 1'b1, 3'b000, 8'd4, 1'b0, "reset");

        // Plain cycle with no pedestrian.
        seq(3'b000, 3, 1, 1'b0, 0, "s1");
        seq(3'b001, 2, 1, 1'b0, 0, "s2");
        seq(3'b110, 1, 1, 1'b0, 0, "s7");
        seq(3'b010, 4, 1, 1'b0, 0, "s3");
        seq(3'b011, 2, 1, 1'b0, 0, "s4");
        seq(3'b111, 1, 1, 1'b0, 0, "s8");

        // Pedestrian pulse in S1 latches, then is served by the walk phase.
        seq(3'b000, 4, 4, 1'b0, 0, "p_s1_entry");
        step(1'b0, 1'b1, 1'b0, 1'b1, 3'b000, 8'd3, 1'b1, "p_latch");
        seq(3'b000, 2, 1, 1'b1, 0, "p_s1");
        seq(3'b001, 2, 1, 1'b1, 0, "p_s2");
        seq(3'b110, 1, 1, 1'b1, 0, "p_s7");
        seq(3'b100, 5, 5, 1'b0, 0, "p_s5_entry");
        step(1'b0, 1'b1, 1'b0, 1'b1, 3'b100, 8'd4, 1'b0, "p_s5_ignore");
        seq(3'b100, 3, 1, 1'b0, 0, "p_s5");
        seq(3'b101, 2, 1, 1'b0, 0, "p_s6");
        seq(3'b111, 1, 1, 1'b0, 0, "p_s8");

        // Request arriving exactly on the S7 exit edge goes straight to S5, no pending left.
        seq(3'b000, 4, 1, 1'b0, 0, "x_s1");
        seq(3'b001, 2, 1, 1'b0, 0, "x_s2");
        seq(3'b110, 1, 1, 1'b0, 0, "x_s7");
        step(1'b0, 1'b1, 1'b0, 1'b1, 3'b100, 8'd5, 1'b0, "x_exit");
        seq(3'b100, 4, 1, 1'b0, 0, "x_s5");
        seq(3'b101, 2, 1, 1'b0, 0, "x_s6");
        seq(3'b111, 1, 1, 1'b0, 0, "x_s8");

        // Hold in S3 discards ticks and freezes remain.
        seq(3'b000, 4, 1, 1'b0, 0, "h_s1");
        seq(3'b001, 2, 1, 1'b0, 0, "h_s2");
        seq(3'b110, 1, 1, 1'b0, 0, "h_s7");
        seq(3'b010, 4, 3, 1'b0, 0, "h_s3a");
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, 1'b1, 1'b0, 3'b010, 8'd3, 1'b0, "h_hold");
        end
        seq(3'b010, 2, 1, 1'b0, 0, "h_s3b");
        seq(3'b011, 2, 1, 1'b0, 0, "h_s4");
        seq(3'b111, 1, 1, 1'b0, 0, "h_s8");

        // Tick every 4th clk stretches each state to duration x 4 clks.
        seq(3'b000, 4, 1, 1'b0, 3, "t_s1");
        seq(3'b001, 2, 1, 1'b0, 3, "t_s2");
        seq(3'b110, 1, 1, 1'b0, 3, "t_s7");
        seq(3'b010, 4, 1, 1'b0, 3, "t_s3");
        seq(3'b011, 2, 1, 1'b0, 3, "t_s4");
        seq(3'b111, 1, 1, 1'b0, 3, "t_s8");

        // Request in S8 latches for the next S7 decision; reset mid-walk abandons the sequence.
        step(1'b0, 1'b0, 1'b0, 1'b1, 3'b111, 8'd1, 1'b1, "r_s8_latch");
        seq(3'b000, 4, 1, 1'b1, 0, "r_s1");
        seq(3'b001, 2, 1, 1'b1, 0, "r_s2");
        seq(3'b110, 1, 1, 1'b1, 0, "r_s7");
        seq(3'b100, 5, 2, 1'b0, 0, "r_s5");
        step(1'b1, 1'b1, 1'b0, 1'b1, 3'b000, 8'd4, 1'b0, "r_reset");
        seq(3'b000, 3, 1, 1'b0, 0, "r_after");
        seq(3'b001, 2, 2, 1'b0, 0, "r_s2_after");

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
